// File: rtl/dram_cache_pkg.sv
// Shared request definitions for the DRAM cache front end:
// opcodes, packet framing constant and the assembled request record.
package dram_cache_pkg;

   typedef enum logic [1:0] {
      OP_READ    = 2'd0,
      OP_WRITE   = 2'd1,
      OP_FLUSH   = 2'd2,
      OP_ILLEGAL = 2'd3
   } op_e;

   localparam int PKT_BYTES = 4;

   typedef struct packed {
      op_e         op;
      logic [5:0]  tag;
      logic [23:0] addr;
   } req_t;

endpackage

// File: rtl/req_packer.sv
// Assembles 4-byte request packets from an upstream byte FIFO and presents
// them to the cache controller with a valid/ready handshake.
module req_packer
   import dram_cache_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   output logic             fifo_read_en,
   input  logic [7:0]       fifo_read_data,
   output logic             pkt_valid,
   input  logic             pkt_ready,
   output logic [1:0]       pkt_op,
   output logic [5:0]       pkt_tag,
   output logic [23:0]      pkt_addr,
   output logic             err_illegal,
   output logic [CNT_W-1:0] pkt_cnt
);

   typedef enum logic {
      COLLECT = 1'b0,
      OUT     = 1'b1
   } state_e;

   // The last byte is consumed straight from the FIFO, so only the first three are stored.
   localparam int SLOTS = PKT_BYTES - 1;

   state_e           state_reg, state_next;
   logic [2:0]       issued_reg, issued_next;
   logic [2:0]       received_reg, received_next;
   logic             rd_pend_reg;
   logic             err_reg, err_next;
   req_t             req_reg, req_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [7:0]       slot_reg [SLOTS];
   logic [SLOTS-1:0] slot_we;
   logic             read_en;
   logic             last_byte;
   op_e              cap_op;

   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_slot_we
         assign slot_we[gi] = rd_pend_reg && (received_reg == 3'(gi));
      end
   endgenerate

   assign last_byte = rd_pend_reg && (received_reg == 3'(SLOTS));
   assign cap_op    = op_e'(slot_reg[0][7:6]);

   always_comb begin
      state_next    = state_reg;
      issued_next   = issued_reg;
      received_next = received_reg;
      err_next      = 1'b0;
      req_next      = req_reg;
      cnt_next      = cnt_reg;
      read_en       = 1'b0;
      case (state_reg)
         COLLECT: begin
            read_en = !fifo_empty && (issued_reg < 3'(PKT_BYTES));
            if (read_en) begin
               issued_next = issued_reg + 3'd1;
            end
            if (rd_pend_reg) begin
               received_next = received_reg + 3'd1;
            end
            if (last_byte) begin
               if (cap_op == OP_ILLEGAL) begin
                  err_next      = 1'b1;
                  issued_next   = '0;
                  received_next = '0;
               end else begin
                  state_next    = OUT;
                  req_next.op   = cap_op;
                  req_next.tag  = slot_reg[0][5:0];
                  req_next.addr = {slot_reg[1], slot_reg[2], fifo_read_data};
               end
            end
         end
         OUT: begin
            if (pkt_ready) begin
               if (cnt_reg != {CNT_W{1'b1}}) begin
                  cnt_next = cnt_reg + 1'b1;
               end
               issued_next   = '0;
               received_next = '0;
               state_next    = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= COLLECT;
         issued_reg   <= '0;
         received_reg <= '0;
         rd_pend_reg  <= 1'b0;
         err_reg      <= 1'b0;
         req_reg      <= '0;
         cnt_reg      <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            slot_reg[i] <= '0;
         end
      end else begin
         state_reg    <= state_next;
         issued_reg   <= issued_next;
         received_reg <= received_next;
         rd_pend_reg  <= fifo_read_en;
         err_reg      <= err_next;
         req_reg      <= req_next;
         cnt_reg      <= cnt_next;
         for (int i = 0; i < SLOTS; i++) begin
            if (slot_we[i]) begin
               slot_reg[i] <= fifo_read_data;
            end
         end
      end
   end

   // Gated by rst_n so the pop request drops immediately when reset asserts.
   assign fifo_read_en = read_en && rst_n;
   assign pkt_valid    = (state_reg == OUT);
   assign pkt_op       = req_reg.op;
   assign pkt_tag      = req_reg.tag;
   assign pkt_addr     = req_reg.addr;
   assign err_illegal  = err_reg;
   assign pkt_cnt      = cnt_reg;

endmodule

// File: tb/tb_req_packer.sv
// Directed bench for req_packer: byte FIFO model, handshake scenarios,
// pause/stall/reset corner cases and a back-to-back throughput run.
module tb_req_packer;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             fifo_empty;
   logic             fifo_read_en;
   logic [7:0]       fifo_read_data = 8'h00;
   logic             pkt_valid;
   logic             pkt_ready = 1'b0;
   logic [1:0]       pkt_op;
   logic [5:0]       pkt_tag;
   logic [23:0]      pkt_addr;
   logic             err_illegal;
   logic [CNT_W-1:0] pkt_cnt;

   int total = 0;
   int bad = 0;

   logic [7:0] mem [0:255];
   int   wr_idx = 0;
   int   rd_idx = 0;
   logic hold_empty = 1'b0;
   int   underflow = 0;
   int   cyc = 0;
   int   last_rd_cyc = 0;
   int   err_cycles = 0;
   int   valid_rises = 0;
   logic prev_valid = 1'b0;

   req_packer #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fifo_empty     (fifo_empty),
      .fifo_read_en   (fifo_read_en),
      .fifo_read_data (fifo_read_data),
      .pkt_valid      (pkt_valid),
      .pkt_ready      (pkt_ready),
      .pkt_op         (pkt_op),
      .pkt_tag        (pkt_tag),
      .pkt_addr       (pkt_addr),
      .err_illegal    (err_illegal),
      .pkt_cnt        (pkt_cnt)
   );

   always #5 clk = ~clk;

   assign fifo_empty = hold_empty || (rd_idx >= wr_idx);

   // FIFO model: data returned the cycle after the pop.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_read_en) begin
         if (rd_idx >= wr_idx) underflow++;
         fifo_read_data <= mem[rd_idx];
         rd_idx <= rd_idx + 1;
      end
   end

   always @(negedge clk) begin
      if (fifo_read_en) last_rd_cyc = cyc;
      if (err_illegal) err_cycles++;
      if (pkt_valid && !prev_valid) valid_rises++;
      prev_valid = pkt_valid;
   end

   task automatic push(input logic [7:0] b);
      mem[wr_idx] = b;
      wr_idx++;
   endtask

   task automatic wait_valid(input string name, output int rc);
      rc = -1;
      for (int k = 0; k < 40; k++) begin
         if (pkt_valid) begin
            rc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (rc < 0) begin
         total++;
         bad++;
         $display("FAIL %s: pkt_valid timeout got=0 want=1", name);
      end else begin
         $display("pkt %s: op=%0d tag=%h addr=%h cyc=%0d", name, pkt_op, pkt_tag, pkt_addr, rc);
      end
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({fifo_read_en, pkt_valid, err_illegal, pkt_op, pkt_tag, pkt_addr, pkt_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_state: got op=%0d tag=%h addr=%h cnt=%0d v=%b rd=%b err=%b want all 0",
                  pkt_op, pkt_tag, pkt_addr, pkt_cnt, pkt_valid, fifo_read_en, err_illegal);
      end
      $display("reset: outputs sampled");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int rc;
      pkt_ready = 1'b1;
      push(8'h45); push(8'h12); push(8'h34); push(8'h56);
      wait_valid("basic", rc);
      total++;
      if (pkt_op !== 2'd1) begin bad++; $display("FAIL basic_op: got=%0d want=1", pkt_op); end
      total++;
      if (pkt_tag !== 6'h05) begin bad++; $display("FAIL basic_tag: got=%h want=05", pkt_tag); end
      total++;
      if (pkt_addr !== 24'h123456) begin bad++; $display("FAIL basic_addr: got=%h want=123456", pkt_addr); end
      total++;
      if (rc - last_rd_cyc !== 2) begin bad++; $display("FAIL basic_latency: got=%0d want=2", rc - last_rd_cyc); end
      @(negedge clk);
      total++;
      if (pkt_cnt !== 16'd1 || pkt_valid !== 1'b0) begin
         bad++; $display("FAIL basic_accept: got cnt=%0d v=%b want cnt=1 v=0", pkt_cnt, pkt_valid);
      end
   endtask

   task automatic test_illegal();
      int rc, e0, v0;
      e0 = err_cycles;
      v0 = valid_rises;
      push(8'hC1); push(8'hAA); push(8'hBB); push(8'hCC);
      repeat (12) @(negedge clk);
      $display("illegal: err cycles=%0d", err_cycles - e0);
      total++;
      if (err_cycles - e0 !== 1) begin bad++; $display("FAIL illegal_err_pulse: got=%0d want=1", err_cycles - e0); end
      total++;
      if (valid_rises !== v0) begin bad++; $display("FAIL illegal_no_valid: got=%0d want=%0d", valid_rises, v0); end
      total++;
      if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL illegal_cnt: got=%0d want=1", pkt_cnt); end
      push(8'h8A); push(8'hDE); push(8'hAD); push(8'h01);
      wait_valid("after_illegal", rc);
      total++;
      if ({pkt_op, pkt_tag, pkt_addr} !== {2'd2, 6'h0A, 24'hDEAD01}) begin
         bad++; $display("FAIL after_illegal_fields: got op=%0d tag=%h addr=%h want op=2 tag=0a addr=dead01",
                         pkt_op, pkt_tag, pkt_addr);
      end
      @(negedge clk);
      total++;
      if (pkt_cnt !== 16'd2) begin bad++; $display("FAIL after_illegal_cnt: got=%0d want=2", pkt_cnt); end
   endtask

   task automatic test_pause();
      int rc, viol;
      push(8'h03); push(8'hAB);
      repeat (4) @(negedge clk);
      hold_empty = 1'b1;
      push(8'hCD); push(8'hEF);
      viol = 0;
      repeat (5) begin
         @(negedge clk);
         if (fifo_read_en !== 1'b0 || pkt_valid !== 1'b0) viol++;
      end
      total++;
      if (viol !== 0) begin bad++; $display("FAIL pause_no_read: got=%0d violations want=0", viol); end
      hold_empty = 1'b0;
      wait_valid("pause", rc);
      total++;
      if ({pkt_op, pkt_tag, pkt_addr} !== {2'd0, 6'h03, 24'hABCDEF}) begin
         bad++; $display("FAIL pause_fields: got op=%0d tag=%h addr=%h want op=0 tag=03 addr=abcdef",
                         pkt_op, pkt_tag, pkt_addr);
      end
      @(negedge clk);
      total++;
      if (pkt_cnt !== 16'd3) begin bad++; $display("FAIL pause_cnt: got=%0d want=3", pkt_cnt); end
   endtask

   task automatic test_stall();
      int rc, viol;
      pkt_ready = 1'b0;
      push(8'h7F); push(8'h11); push(8'h22); push(8'h33);
      push(8'h42); push(8'h00); push(8'h00); push(8'h42);
      wait_valid("stall", rc);
      total++;
      if ({pkt_op, pkt_tag, pkt_addr} !== {2'd1, 6'h3F, 24'h112233}) begin
         bad++; $display("FAIL stall_fields: got op=%0d tag=%h addr=%h want op=1 tag=3f addr=112233",
                         pkt_op, pkt_tag, pkt_addr);
      end
      viol = 0;
      repeat (10) begin
         @(negedge clk);
         if (pkt_valid !== 1'b1 || fifo_read_en !== 1'b0 ||
             {pkt_op, pkt_tag, pkt_addr} !== {2'd1, 6'h3F, 24'h112233} || pkt_cnt !== 16'd3) viol++;
      end
      total++;
      if (viol !== 0) begin bad++; $display("FAIL stall_hold: got=%0d violations want=0", viol); end
      pkt_ready = 1'b1;
      @(negedge clk);
      total++;
      if (pkt_cnt !== 16'd4 || pkt_valid !== 1'b0) begin
         bad++; $display("FAIL stall_accept: got cnt=%0d v=%b want cnt=4 v=0", pkt_cnt, pkt_valid);
      end
      wait_valid("stall_next", rc);
      total++;
      if ({pkt_op, pkt_tag, pkt_addr} !== {2'd1, 6'h02, 24'h000042}) begin
         bad++; $display("FAIL stall_next_fields: got op=%0d tag=%h addr=%h want op=1 tag=02 addr=000042",
                         pkt_op, pkt_tag, pkt_addr);
      end
      @(negedge clk);
      total++;
      if (pkt_cnt !== 16'd5) begin bad++; $display("FAIL stall_next_cnt: got=%0d want=5", pkt_cnt); end
   endtask

   task automatic test_mid_reset();
      int rc;
      push(8'h41); push(8'h99);
      repeat (4) @(negedge clk);
      push(8'h55);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({fifo_read_en, pkt_valid, err_illegal, pkt_op, pkt_tag, pkt_addr, pkt_cnt} !== '0) begin
         bad++; $display("FAIL async_reset: got op=%0d tag=%h addr=%h cnt=%0d rd=%b want all 0",
                         pkt_op, pkt_tag, pkt_addr, pkt_cnt, fifo_read_en);
      end
      $display("mid_reset: outputs sampled during reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push(8'h66); push(8'h77); push(8'h88);
      wait_valid("post_reset", rc);
      total++;
      if ({pkt_op, pkt_tag, pkt_addr} !== {2'd1, 6'h15, 24'h667788}) begin
         bad++; $display("FAIL post_reset_fields: got op=%0d tag=%h addr=%h want op=1 tag=15 addr=667788",
                         pkt_op, pkt_tag, pkt_addr);
      end
      @(negedge clk);
      total++;
      if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL post_reset_cnt: got=%0d want=1", pkt_cnt); end
   endtask

   task automatic test_back_to_back();
      int rc, prev_rc;
      logic [1:0]  eo;
      logic [5:0]  et;
      logic [23:0] ea;
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) begin
         eo = 2'(i % 3);
         et = 6'(i + 1);
         ea = {8'(i), 8'(8'hF0 - 8'(i)), 8'(i * 7)};
         push({eo, et}); push(ea[23:16]); push(ea[15:8]); push(ea[7:0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      prev_rc = 0;
      for (int i = 0; i < 16; i++) begin
         eo = 2'(i % 3);
         et = 6'(i + 1);
         ea = {8'(i), 8'(8'hF0 - 8'(i)), 8'(i * 7)};
         wait_valid("b2b", rc);
         total++;
         if ({pkt_op, pkt_tag, pkt_addr} !== {eo, et, ea}) begin
            bad++; $display("FAIL b2b_fields[%0d]: got op=%0d tag=%h addr=%h want op=%0d tag=%h addr=%h",
                            i, pkt_op, pkt_tag, pkt_addr, eo, et, ea);
         end
         if (i > 0) begin
            total++;
            if (rc - prev_rc !== 6) begin bad++; $display("FAIL b2b_period[%0d]: got=%0d want=6", i, rc - prev_rc); end
         end
         prev_rc = rc;
         @(negedge clk);
      end
      total++;
      if (pkt_cnt !== 16'd16) begin bad++; $display("FAIL b2b_cnt: got=%0d want=16", pkt_cnt); end
      total++;
      if (underflow !== 0) begin bad++; $display("FAIL no_underflow: got=%0d want=0", underflow); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_illegal();
      test_pause();
      test_stall();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
